// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   uart_state_e  : bit-level framing FSM encoding (IDLE, START, DATA, STOP, DONE)
//   pkt_state_e   : packet sequencer encoding used by the multi-byte transmitter
//   calc_bps_cnt  : clock cycles per bit for a given clock frequency and baud rate
package uart_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StDone
   } uart_state_e;

   typedef enum logic [1:0] {
      PktIdle,
      PktSend,
      PktDone
   } pkt_state_e;

   function automatic int unsigned calc_bps_cnt(input int unsigned clk_freq,
                                                input int unsigned baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-byte UART serializer: start bit 0, 8 data bits LSB first, STOP_BITS stop bits of 1.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   start    : load data and begin a frame; honoured when idle or in the final stop-bit cycle
//   data     : byte to send, sampled together with start
//   txd      : registered serial output, idle high
//   busy     : high while a frame is in progress
//   done     : high during the last cycle of the last stop bit
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int unsigned BPS_CNT   = 434,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] data,
   output logic       txd,
   output logic       busy,
   output logic       done
);

   localparam int unsigned BW = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
   localparam logic [BW-1:0] BaudLast = BW'(BPS_CNT - 1);
   localparam logic [2:0] StopLast = 3'(STOP_BITS - 1);

   uart_state_e   state_q, state_d;
   logic [BW-1:0] baud_q, baud_d;
   logic [2:0]    bit_q, bit_d;      // data bit index, reused as stop-bit index
   logic [7:0]    shreg_q, shreg_d;
   logic          txd_q, txd_d;
   logic          baud_end;

   assign baud_end = (baud_q == BaudLast);
   assign done     = (state_q == StStop) && baud_end && (bit_q == StopLast);
   assign busy     = (state_q != StIdle);
   assign txd      = txd_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         baud_q  <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      txd_d   = txd_q;

      if (state_q != StIdle) begin
         baud_d = baud_end ? '0 : baud_q + 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StStart;
               shreg_d = data;
               txd_d   = 1'b0;
               baud_d  = '0;
               bit_d   = '0;
            end
         end
         StStart: begin
            if (baud_end) begin
               state_d = StData;
               txd_d   = shreg_q[0];
               bit_d   = '0;
            end
         end
         StData: begin
            if (baud_end) begin
               if (bit_q == 3'd7) begin
                  state_d = StStop;
                  txd_d   = 1'b1;
                  bit_d   = '0;
               end else begin
                  bit_d   = bit_q + 3'd1;
                  shreg_d = {1'b0, shreg_q[7:1]};
                  txd_d   = shreg_q[1];
               end
            end
         end
         StStop: begin
            if (baud_end) begin
               if (bit_q == StopLast) begin
                  // Chaining straight into the next start bit keeps frames gap-free.
                  if (start) begin
                     state_d = StStart;
                     shreg_d = data;
                     txd_d   = 1'b0;
                     bit_d   = '0;
                  end else begin
                     state_d = StIdle;
                     txd_d   = 1'b1;
                     bit_d   = '0;
                  end
               end else begin
                  bit_d = bit_q + 3'd1;
               end
            end
         end
         default: begin
            state_d = StIdle;
            txd_d   = 1'b1;
            bit_d   = '0;
            baud_d  = '0;
         end
      endcase
   end

endmodule

// File: rtl/uart_mult_byte_tx.sv
// Multi-byte UART packet transmitter: sends tx_len bytes of tx_data back to back.
// Ports:
//   sys_clk, sys_rst : clock and synchronous active-high reset
//   tx_start         : single-cycle request, sampled only while tx_busy is low
//   tx_len           : byte count, legal 1..MAX_BYTES; anything else pulses tx_err
//   tx_data          : payload, byte k at [8k+7:8k]
//   uart_txd         : serial line, idle high
//   tx_busy          : high from the first start bit through the last stop bit
//   byte_done        : one-cycle pulse right after each byte's last stop bit
//   tx_done          : one-cycle pulse after the packet; a new request may be accepted here
//   tx_err           : one-cycle pulse after a rejected request
//   tx_byte_cnt      : bytes fully sent in the current packet
module uart_mult_byte_tx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50_000_000,
   parameter int unsigned UART_BPS  = 115200,
   parameter int unsigned MAX_BYTES = 12,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                   sys_clk,
   input  logic                   sys_rst,
   input  logic                   tx_start,
   input  logic [3:0]             tx_len,
   input  logic [8*MAX_BYTES-1:0] tx_data,
   output logic                   uart_txd,
   output logic                   tx_busy,
   output logic                   byte_done,
   output logic                   tx_done,
   output logic                   tx_err,
   output logic [3:0]             tx_byte_cnt
);

   localparam int unsigned BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);
   localparam logic [4:0] MaxLen = 5'(MAX_BYTES);

   pkt_state_e             pkt_q, pkt_d;
   logic [3:0]             len_q, len_d;
   logic [3:0]             next_q, next_d;   // index of the next byte to hand to the serializer
   logic [3:0]             cnt_q, cnt_d;
   logic [8*MAX_BYTES-1:0] data_q, data_d;
   logic                   err_q, err_d;
   logic                   bdone_q, bdone_d;
   logic                   accept, len_ok, byte_start, byte_fin, byte_busy;
   logic [7:0]             byte_data;

   assign len_ok = (tx_len != 4'd0) && ({1'b0, tx_len} <= MaxLen);
   assign accept = tx_start && !tx_busy && !sys_rst;

   // Byte 0 goes straight from the input so its start bit appears the cycle after accept.
   assign byte_data = (pkt_q == PktSend) ? data_q[{next_q, 3'b000} +: 8] : tx_data[7:0];

   uart_byte_tx #(
      .BPS_CNT   (BPS_CNT),
      .STOP_BITS (STOP_BITS)
   ) u_byte_tx (
      .clk   (sys_clk),
      .rst   (sys_rst),
      .start (byte_start),
      .data  (byte_data),
      .txd   (uart_txd),
      .busy  (byte_busy),
      .done  (byte_fin)
   );

   // The serializer stays busy across chained bytes, so its busy is the packet busy.
   assign tx_busy     = byte_busy;
   assign tx_done     = (pkt_q == PktDone);
   assign tx_err      = err_q;
   assign byte_done   = bdone_q;
   assign tx_byte_cnt = cnt_q;

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pkt_q   <= PktIdle;
         len_q   <= '0;
         next_q  <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         bdone_q <= 1'b0;
      end else begin
         pkt_q   <= pkt_d;
         len_q   <= len_d;
         next_q  <= next_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         err_q   <= err_d;
         bdone_q <= bdone_d;
      end
   end

   always_comb begin
      pkt_d      = pkt_q;
      len_d      = len_q;
      next_d     = next_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      err_d      = 1'b0;
      bdone_d    = byte_fin;
      byte_start = 1'b0;

      if (byte_fin) begin
         cnt_d = cnt_q + 4'd1;
      end

      unique case (pkt_q)
         PktIdle, PktDone: begin
            pkt_d = PktIdle;
            if (accept) begin
               if (len_ok) begin
                  pkt_d      = PktSend;
                  byte_start = 1'b1;
                  len_d      = tx_len;
                  data_d     = tx_data;
                  next_d     = 4'd1;
                  cnt_d      = '0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         PktSend: begin
            if (byte_fin) begin
               if (next_q < len_q) begin
                  byte_start = 1'b1;
                  next_d     = next_q + 4'd1;
               end else begin
                  pkt_d = PktDone;
               end
            end
         end
         default: pkt_d = PktIdle;
      endcase
   end

endmodule

// File: tb/tb_uart_mult_byte_tx.sv
// Directed bench for uart_mult_byte_tx. Two instances share the stimulus: u_dut1 with one
// stop bit and u_dut2 with two. A small clock/baud ratio (10 cycles per bit) keeps runs short.
module tb_uart_mult_byte_tx;

   localparam int unsigned CLK_FREQ = 1000;
   localparam int unsigned UART_BPS = 100;
   localparam int BPS = 10;

   logic        clk = 1'b0;
   logic        rst, start1, start2, sel;
   logic [3:0]  len;
   logic [95:0] data;

   logic       txd1, busy1, bd1, done1, err1;
   logic       txd2, busy2, bd2, done2, err2;
   logic [3:0] cnt1, cnt2;
   logic       txd, busy, bd, done, err;
   logic [3:0] cnt;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_mult_byte_tx #(
      .CLK_FREQ (CLK_FREQ), .UART_BPS (UART_BPS), .MAX_BYTES (12), .STOP_BITS (1)
   ) u_dut1 (
      .sys_clk (clk), .sys_rst (rst), .tx_start (start1), .tx_len (len), .tx_data (data),
      .uart_txd (txd1), .tx_busy (busy1), .byte_done (bd1), .tx_done (done1), .tx_err (err1),
      .tx_byte_cnt (cnt1)
   );

   uart_mult_byte_tx #(
      .CLK_FREQ (CLK_FREQ), .UART_BPS (UART_BPS), .MAX_BYTES (12), .STOP_BITS (2)
   ) u_dut2 (
      .sys_clk (clk), .sys_rst (rst), .tx_start (start2), .tx_len (len), .tx_data (data),
      .uart_txd (txd2), .tx_busy (busy2), .byte_done (bd2), .tx_done (done2), .tx_err (err2),
      .tx_byte_cnt (cnt2)
   );

   assign txd  = sel ? txd2  : txd1;
   assign busy = sel ? busy2 : busy1;
   assign bd   = sel ? bd2   : bd1;
   assign done = sel ? done2 : done1;
   assign err  = sel ? err2  : err1;
   assign cnt  = sel ? cnt2  : cnt1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Pulse tx_start on the selected instance; returns in the first cycle after acceptance.
   task automatic launch();
      if (sel) start2 = 1'b1;
      else     start1 = 1'b1;
      step();
      start1 = 1'b0;
      start2 = 1'b0;
   endtask

   // Checks every cycle of an n-byte packet starting at the first start-bit cycle and ends in
   // the tx_done cycle. poke_byte: send an ignored tx_start (with new len/data) during that
   // byte. abort_byte: assert reset during data bit 3 of that byte and check the aftermath.
   task automatic play_packet(input int n, input logic [95:0] d, input int poke_byte,
                              input int abort_byte);
      int   sb = sel ? 2 : 1;
      logic exp_bit;
      for (int b = 0; b < n; b++) begin
         for (int k = 0; k < 9 + sb; k++) begin
            for (int c = 0; c < BPS; c++) begin
               if (k == 0)      exp_bit = 1'b0;
               else if (k <= 8) exp_bit = d[8*b+k-1];
               else             exp_bit = 1'b1;
               chk("txd", {31'b0, txd}, {31'b0, exp_bit});
               chk("busy", {31'b0, busy}, 32'd1);
               chk("byte_done", {31'b0, bd}, {31'b0, (b > 0 && k == 0 && c == 0)});
               chk("byte_cnt", {28'b0, cnt}, b);
               chk("tx_done_early", {31'b0, done}, 32'd0);
               chk("tx_err_busy", {31'b0, err}, 32'd0);
               if (b == poke_byte && k == 3 && c == 0) begin
                  if (sel) start2 = 1'b1;
                  else     start1 = 1'b1;
                  len  = 4'd1;
                  data = '1;
               end
               if (b == abort_byte && k == 4 && c == 3) begin
                  rst = 1'b1;
                  step();
                  rst = 1'b0;
                  chk("rst_txd", {31'b0, txd}, 32'd1);
                  chk("rst_busy", {31'b0, busy}, 32'd0);
                  chk("rst_cnt", {28'b0, cnt}, 32'd0);
                  chk("rst_byte_done", {31'b0, bd}, 32'd0);
                  chk("rst_tx_done", {31'b0, done}, 32'd0);
                  for (int i = 0; i < 150; i++) begin
                     step();
                     chk("abort_no_done", {31'b0, done}, 32'd0);
                     chk("abort_txd_idle", {31'b0, txd}, 32'd1);
                     chk("abort_busy", {31'b0, busy}, 32'd0);
                  end
                  return;
               end
               step();
               start1 = 1'b0;
               start2 = 1'b0;
            end
         end
      end
      chk("done_pulse", {31'b0, done}, 32'd1);
      chk("done_busy", {31'b0, busy}, 32'd0);
      chk("done_byte_done", {31'b0, bd}, 32'd1);
      chk("done_cnt", {28'b0, cnt}, n);
      chk("done_txd", {31'b0, txd}, 32'd1);
   endtask

   initial begin
      logic [95:0] pkt;
      rst    = 1'b1;
      start1 = 1'b0;
      start2 = 1'b0;
      sel    = 1'b0;
      len    = '0;
      data   = '0;
      repeat (3) step();
      rst = 1'b0;

      // Reset state of both instances
      chk("reset_txd1", {31'b0, txd1}, 32'd1);
      chk("reset_busy1", {31'b0, busy1}, 32'd0);
      chk("reset_done1", {31'b0, done1}, 32'd0);
      chk("reset_err1", {31'b0, err1}, 32'd0);
      chk("reset_bd1", {31'b0, bd1}, 32'd0);
      chk("reset_cnt1", {28'b0, cnt1}, 32'd0);
      chk("reset_txd2", {31'b0, txd2}, 32'd1);
      chk("reset_busy2", {31'b0, busy2}, 32'd0);
      chk("reset_cnt2", {28'b0, cnt2}, 32'd0);

      // Single byte 0x5A: line 0,0,1,0,1,1,0,1,0,1
      step();
      len  = 4'd1;
      data = '0;
      data[7:0] = 8'h5A;
      pkt = data;
      launch();
      play_packet(1, pkt, -1, -1);
      step();
      chk("after_done_pulse", {31'b0, done}, 32'd0);
      chk("after_done_bd", {31'b0, bd}, 32'd0);
      chk("cnt_holds", {28'b0, cnt}, 32'd1);

      // Full 12-byte packet 0x00..0x0B
      for (int i = 0; i < 12; i++) data[8*i +: 8] = 8'(i);
      len = 4'd12;
      pkt = data;
      launch();
      play_packet(12, pkt, -1, -1);
      step();

      // Illegal lengths 0 and 13
      len = 4'd0;
      launch();
      chk("err_len0", {31'b0, err}, 32'd1);
      chk("err_len0_txd", {31'b0, txd}, 32'd1);
      chk("err_len0_busy", {31'b0, busy}, 32'd0);
      step();
      chk("err_len0_pulse", {31'b0, err}, 32'd0);
      chk("err_len0_idle", {31'b0, busy}, 32'd0);
      len = 4'd13;
      launch();
      chk("err_len13", {31'b0, err}, 32'd1);
      chk("err_len13_txd", {31'b0, txd}, 32'd1);
      chk("err_len13_busy", {31'b0, busy}, 32'd0);
      step();
      chk("err_len13_pulse", {31'b0, err}, 32'd0);
      chk("err_len13_txd2", {31'b0, txd}, 32'd1);

      // 4-byte packet with an ignored tx_start during byte 2
      data = '0;
      data[31:0] = 32'h81F03CA5;
      len  = 4'd4;
      pkt  = data;
      launch();
      play_packet(4, pkt, 2, -1);

      // Back-to-back: request in the tx_done cycle
      data = '0;
      data[7:0] = 8'h96;
      len = 4'd1;
      pkt = data;
      launch();
      chk("b2b_start_bit", {31'b0, txd}, 32'd0);
      play_packet(1, pkt, -1, -1);
      step();

      // Reset during data bit 3 of byte 5 of an 8-byte packet
      data = '0;
      data[63:0] = 64'h0123456789ABCDEF;
      len  = 4'd8;
      pkt  = data;
      launch();
      play_packet(8, pkt, -1, 5);

      // tx_start during reset is ignored
      rst    = 1'b1;
      start1 = 1'b1;
      len    = 4'd1;
      step();
      rst    = 1'b0;
      start1 = 1'b0;
      chk("rst_start_busy", {31'b0, busy}, 32'd0);
      chk("rst_start_txd", {31'b0, txd}, 32'd1);
      step();
      chk("rst_start_busy2", {31'b0, busy}, 32'd0);
      chk("rst_start_err", {31'b0, err}, 32'd0);

      // Two stop bits: 2 bytes of 11 bit times each
      sel  = 1'b1;
      data = '0;
      data[15:0] = 16'h18C3;
      len  = 4'd2;
      pkt  = data;
      launch();
      play_packet(2, pkt, -1, -1);
      step();
      chk("sb2_done_pulse", {31'b0, done}, 32'd0);
      chk("sb2_cnt", {28'b0, cnt}, 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_mult_byte_tx.md
UART_MULT_BYTE_TX -- requirements
Module: uart_mult_byte_tx

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning sys_clk frequency in Hz.
REQ-002 SHALL have parameter UART_BPS, default 115200, meaning line baud rate.
REQ-003 SHALL have parameter MAX_BYTES, default 12, meaning packet capacity in bytes, matching the 12-byte receive packet.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits per byte; legal values are 1 and 2.
REQ-005 SHALL have port sys_clk, input, 1 bit: single clock; all logic is on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port tx_start, input, 1 bit: single-cycle packet request.
REQ-008 SHALL have port tx_len, input, 4 bits: number of bytes to send; legal range is 1..MAX_BYTES.
REQ-009 SHALL have port tx_data, input, 8*MAX_BYTES bits: packet payload; byte k occupies [8k+7:8k].
REQ-010 SHALL have port uart_txd, output, 1 bit: serial line, idle high.
REQ-011 SHALL have port tx_busy, output, 1 bit: high while a packet is being sent.
REQ-012 SHALL have port byte_done, output, 1 bit: one-cycle pulse at the end of each byte's last stop bit.
REQ-013 SHALL have port tx_done, output, 1 bit: one-cycle pulse when the packet completes.
REQ-014 SHALL have port tx_err, output, 1 bit: one-cycle pulse when a request is rejected.
REQ-015 SHALL have port tx_byte_cnt, output, 4 bits: number of bytes fully sent in the current packet.

Function
REQ-016 SHALL define BPS_CNT = CLK_FREQ/UART_BPS (integer division, 434 at the defaults); every bit lasts exactly BPS_CNT cycles.
REQ-017 SHALL sample tx_start only when tx_busy=0.
  - On acceptance, tx_len and tx_data are latched; later changes to those inputs have no effect.
  - tx_start while tx_busy=1 is ignored: no error, no state change.
REQ-018 SHALL handle an illegal tx_len (0 or >MAX_BYTES) at acceptance as follows: no transmission, tx_err pulses in the next cycle, uart_txd stays high.
REQ-019 SHALL implement FSM states IDLE, START, DATA, STOP, DONE with these transitions:
  - IDLE->START on a legal accept.
  - START->DATA after 1 bit time.
  - DATA->STOP after 8 bits.
  - STOP->START after STOP_BITS bit times, if bytes remain.
  - STOP->DONE after STOP_BITS bit times, otherwise.
  - DONE->IDLE after 1 cycle.
REQ-020 SHALL frame each byte as 8N1 (or 8N2): start bit 0, data LSB first, stop bit(s) 1, with no idle gap between bytes.
REQ-021 SHALL drive uart_txd from a register; the start bit of byte 0 appears at cycle N+1 when acceptance is at rising edge N.
REQ-022 SHALL keep tx_busy high from cycle N+1 through the last stop-bit cycle; tx_busy is low in the DONE cycle.
REQ-023 SHALL pulse tx_done in the DONE cycle; a tx_start presented in that cycle is accepted, giving back-to-back packets.
REQ-024 SHALL increment tx_byte_cnt together with each byte_done pulse; it holds its final value after tx_done and clears on the next accept.
REQ-025 SHALL make packet duration exactly tx_len*(9+STOP_BITS)*BPS_CNT cycles, from the first start-bit cycle to the end of the last stop bit.
REQ-026 SHALL size the baud counter as clog2(BPS_CNT) bits; it wraps to 0 at BPS_CNT-1 and never overflows.

Reset
REQ-027 SHALL put the block in the following state on a sampled sys_rst=1, including mid-packet, in the following cycle:
  - State IDLE.
  - uart_txd=1; tx_busy, byte_done, tx_done and tx_err = 0.
  - tx_byte_cnt=0; all counters 0.
  - The in-progress packet is abandoned, and no tx_done is issued for it.
REQ-028 SHALL ignore tx_start in any cycle where sys_rst=1.

Structure
REQ-029 SHALL place the FSM state encoding and the BPS_CNT computation helper in a shared package, uart_pkg, which is also usable by the receiver.
REQ-030 SHALL contain one sub-module, uart_byte_tx (single-byte serializer with start/busy/done); the parent owns packet sequencing and byte selection.

Verification
REQ-031 SHALL cover a single byte: tx_len=1, byte0=0x5A -> line shows 0,0,1,0,1,1,0,1,0,1, each bit 434 cycles; tx_done at 4340 cycles after the start bit; tx_byte_cnt=1.
REQ-032 SHALL cover a full packet: tx_len=12, bytes 0x00..0x0B -> 12 contiguous frames, 52080 cycles, 12 byte_done pulses, one tx_done; loopback into uart_mult_byte_rx yields rev_data0..11 = 0x00..0x0B.
REQ-033 SHALL cover an illegal length: tx_len=0, then tx_len=13 -> tx_err pulses once for each request; uart_txd stays high; tx_busy stays 0.
REQ-034 SHALL cover busy and back-to-back behaviour:
  - tx_start during byte 2 of a 4-byte packet -> ignored, and the packet is unchanged.
  - tx_start in the tx_done cycle -> new start bit in the next cycle.
REQ-035 SHALL cover reset mid-packet: sys_rst=1 during the DATA bit 3 of byte 5 -> next cycle uart_txd=1, tx_busy=0, tx_byte_cnt=0, no tx_done pulse.
REQ-036 SHALL cover STOP_BITS=2: tx_len=2 -> each frame is 11 bit times; total 9548 cycles.
